// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN output-layer blocks: FP32 field layout,
// arbiter state encoding and requester IDs.
package dqn_pkg;

    localparam int FP32_WIDTH    = 32;
    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MAN_MSB  = 22;
    localparam int FP32_MAN_LSB  = 0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } arb_state_t;

    localparam logic REQ_TARGET = 1'b0;
    localparam logic REQ_POLICY = 1'b1;

    function automatic logic fp32_sign(input logic [FP32_WIDTH-1:0] v);
        return v[FP32_SIGN_BIT];
    endfunction

    // Exponent and mantissa concatenated: the magnitude as an ordered integer.
    function automatic logic [FP32_WIDTH-2:0] fp32_mag(input logic [FP32_WIDTH-1:0] v);
        return {v[FP32_EXP_MSB:FP32_EXP_LSB], v[FP32_MAN_MSB:FP32_MAN_LSB]};
    endfunction

endpackage

// File: rtl/fp32_greater.sv
// Combinational strict greater-than on raw IEEE-754 single bits.
// Signed zeros compare equal; NaN/Inf are ordered by their bit patterns.
module fp32_greater
    import dqn_pkg::*;
(
    input  logic [FP32_WIDTH-1:0] a,
    input  logic [FP32_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    logic                  sign_a;
    logic                  sign_b;
    logic [FP32_WIDTH-2:0] mag_a;
    logic [FP32_WIDTH-2:0] mag_b;

    assign sign_a = fp32_sign(a);
    assign sign_b = fp32_sign(b);
    assign mag_a  = fp32_mag(a);
    assign mag_b  = fp32_mag(b);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        a_gt_b = 1'b0;
        case ({sign_a, sign_b})
            2'b00:   a_gt_b = (mag_a > mag_b);
            2'b11:   a_gt_b = (mag_a < mag_b);
            // Positive beats negative unless both are zero (+0 == -0).
            2'b01:   a_gt_b = (|mag_a) || (|mag_b);
            default: a_gt_b = 1'b0;
        endcase
    end

endmodule

// File: rtl/target_max_arbiter.sv
// Round-robin shared max/argmax engine: one requester owns a whole frame,
// the frame is reduced serially and the max, its index and the owner are reported.
module target_max_arbiter
    import dqn_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int NUMBER_OF_OUTPUT_NODE = 3,
    parameter int INDEX_WIDTH           = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [DATA_WIDTH-1:0]  req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [DATA_WIDTH-1:0]  req1_data,
    output logic                   req1_ready,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic                   o_id
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

    arb_state_t             state;
    arb_state_t             state_next;
    logic                   grant_id;
    logic                   grant_next;
    logic                   prio;
    logic [INDEX_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]  best_val;
    logic [INDEX_WIDTH-1:0] best_idx;

    logic                   beat_valid;
    logic [DATA_WIDTH-1:0]  beat_data;
    logic                   accept;
    logic                   last_beat;
    logic                   beat_gt;
    logic                   take_beat;
    logic [DATA_WIDTH-1:0]  cand_val;
    logic [INDEX_WIDTH-1:0] cand_idx;

    // Ready depends only on registered state, so valid never loops back into ready.
    assign beat_valid = (grant_id == REQ_POLICY) ? req1_valid : req0_valid;
    assign beat_data  = (grant_id == REQ_POLICY) ? req1_data  : req0_data;
    assign accept     = (state == ST_COLLECT) && beat_valid;
    assign last_beat  = (count == LAST_IDX);

    fp32_greater u_cmp (
        .a      (beat_data),
        .b      (best_val),
        .a_gt_b (beat_gt)
    );

    // Beat 0 always loads; later beats replace only when strictly greater.
    assign take_beat = (count == '0) || beat_gt;
    assign cand_val  = take_beat ? beat_data : best_val;
    assign cand_idx  = take_beat ? count     : best_idx;

    always_comb begin
        state_next = state;
        grant_next = grant_id;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_next = ST_COLLECT;
                    if (req0_valid && req1_valid) begin
                        grant_next = prio;
                    end else begin
                        grant_next = req1_valid ? REQ_POLICY : REQ_TARGET;
                    end
                end
            end
            ST_COLLECT: begin
                req0_ready = (grant_id == REQ_TARGET);
                req1_ready = (grant_id == REQ_POLICY);
                if (accept && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst_n) begin
            state    <= ST_IDLE;
            grant_id <= REQ_TARGET;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            prio     <= REQ_TARGET;
            count    <= '0;
            best_val <= '0;
            best_idx <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_index  <= '0;
            o_id     <= REQ_TARGET;
        end else begin
            o_valid <= 1'b0;
            if ((state == ST_IDLE) && (req0_valid || req1_valid)) begin
                count <= '0;
            end
            if (accept) begin
                best_val <= cand_val;
                best_idx <= cand_idx;
                if (last_beat) begin
                    o_valid <= 1'b1;
                    o_data  <= cand_val;
                    o_index <= cand_idx;
                    o_id    <= grant_id;
                    prio    <= ~grant_id;
                    count   <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_target_max_arbiter.sv
// Directed bench for target_max_arbiter: inputs change and outputs are sampled
// on the falling edge; expected values are hand-computed.
module tb_target_max_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_index;
    logic        o_id;

    int errors = 0;
    int checks = 0;

    logic [31:0] tab0 [2][3] = '{'{32'h3f800000, 32'h40000000, 32'h3f000000},
                                 '{32'h41000000, 32'h40000000, 32'h40e00000}};
    logic [31:0] tab1 [2][3] = '{'{32'h40400000, 32'h3f800000, 32'h40800000},
                                 '{32'hc0000000, 32'hc0800000, 32'hbf800000}};

    always #5 clk = ~clk;

    target_max_arbiter #(
        .DATA_WIDTH            (32),
        .NUMBER_OF_OUTPUT_NODE (3),
        .INDEX_WIDTH           (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_index    (o_index),
        .o_id       (o_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit id, input logic v, input logic [31:0] d);
        if (id) begin
            req1_valid = v;
            req1_data  = d;
        end else begin
            req0_valid = v;
            req0_data  = d;
        end
    endtask

    // Sends one 3-beat frame from an idle engine, optionally dropping valid for
    // gap_len cycles after beat gap_after, then checks the result strobe.
    task automatic send_frame(input bit id, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input int gap_after, input int gap_len,
                              input logic [31:0] exp_data, input logic [1:0] exp_idx,
                              input int exp_cycles, input string tag);
        logic [31:0] d [3];
        int k   = 0;
        int cyc = 0;
        bit rdy;
        bit other_seen = 0;
        bit early_valid = 0;
        d = '{d0, d1, d2};
        set_req(id, 1'b1, d[0]);
        while (k < 3 && cyc < 40) begin
            rdy = id ? req1_ready : req0_ready;
            if (id ? req0_ready : req1_ready) other_seen = 1;
            if (o_valid) early_valid = 1;
            @(negedge clk);
            cyc++;
            if (rdy && (id ? req1_valid : req0_valid)) begin
                k++;
                if (k < 3) begin
                    if (k == gap_after + 1 && gap_len > 0) begin
                        set_req(id, 1'b0, 32'h0);
                        repeat (gap_len) begin
                            if (o_valid) early_valid = 1;
                            @(negedge clk);
                            cyc++;
                        end
                    end
                    set_req(id, 1'b1, d[k]);
                end
            end
        end
        set_req(id, 1'b0, 32'h0);
        check({tag, " beats_accepted"}, k, 3);
        check({tag, " latency"}, cyc, exp_cycles);
        check({tag, " no_early_valid"}, {31'd0, early_valid}, 0);
        check({tag, " other_ready_low"}, {31'd0, other_seen}, 0);
        check({tag, " o_valid"}, {31'd0, o_valid}, 1);
        check({tag, " o_data"}, o_data, exp_data);
        check({tag, " o_index"}, {30'd0, o_index}, {30'd0, exp_idx});
        check({tag, " o_id"}, {31'd0, o_id}, {31'd0, id});
        check({tag, " ready_dropped"}, {31'd0, (id ? req1_ready : req0_ready)}, 0);
        @(negedge clk);
        check({tag, " o_valid_one_cycle"}, {31'd0, o_valid}, 0);
    endtask

    initial begin
        int k0, k1, f0, f1, n;
        bit r0, r1, both_rdy, stray_valid;
        logic        ids  [4];
        logic [31:0] vals [4];

        rst_n      = 1'b1;
        req0_valid = 1'b0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        check("reset req0_ready", {31'd0, req0_ready}, 0);
        check("reset req1_ready", {31'd0, req1_ready}, 0);
        check("reset o_valid", {31'd0, o_valid}, 0);
        check("reset o_data", o_data, 0);
        check("reset o_index", {30'd0, o_index}, 0);
        check("reset o_id", {31'd0, o_id}, 0);

        // Positive frame from requester 0
        send_frame(1'b0, 32'h42e26279, 32'h42f3282c, 32'h42c617e1, -1, 0,
                   32'h42f3282c, 2'd1, 4, "req0_pos");

        // Requester 1 with a 2-cycle valid gap after beat 1
        send_frame(1'b1, 32'h42e26279, 32'h42f3282c, 32'h42f40000, 1, 2,
                   32'h42f40000, 2'd2, 6, "req1_gap");

        // All-negative frame: -2, -1, -3
        send_frame(1'b0, 32'hc0000000, 32'hbf800000, 32'hc0400000, -1, 0,
                   32'hbf800000, 2'd1, 4, "negatives");

        // Signed-zero tie keeps the first beat
        send_frame(1'b1, 32'h80000000, 32'h00000000, 32'h80000000, -1, 0,
                   32'h80000000, 2'd0, 4, "signed_zero");

        // Both requesters valid from reset, two frames each
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        k0 = 0; k1 = 0; f0 = 0; f1 = 0; n = 0;
        both_rdy = 0;
        req0_valid = 1'b1;
        req0_data  = tab0[0][0];
        req1_valid = 1'b1;
        req1_data  = tab1[0][0];
        for (int cyc = 0; cyc < 200 && (f0 < 2 || f1 < 2); cyc++) begin
            r0 = req0_ready;
            r1 = req1_ready;
            if (r0 && r1) both_rdy = 1;
            @(negedge clk);
            if (r0 && req0_valid) begin
                k0++;
                if (k0 == 3) begin
                    k0 = 0;
                    f0++;
                end
                if (f0 < 2) req0_data = tab0[f0][k0];
                else req0_valid = 1'b0;
            end
            if (r1 && req1_valid) begin
                k1++;
                if (k1 == 3) begin
                    k1 = 0;
                    f1++;
                end
                if (f1 < 2) req1_data = tab1[f1][k1];
                else req1_valid = 1'b0;
            end
            if (o_valid && n < 4) begin
                ids[n]  = o_id;
                vals[n] = o_data;
                n++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr result_count", n, 4);
        check("rr never_both_ready", {31'd0, both_rdy}, 0);
        check("rr grant0", {31'd0, ids[0]}, 0);
        check("rr grant1", {31'd0, ids[1]}, 1);
        check("rr grant2", {31'd0, ids[2]}, 0);
        check("rr grant3", {31'd0, ids[3]}, 1);
        check("rr data0", vals[0], 32'h40000000);
        check("rr data1", vals[1], 32'h40800000);
        check("rr data2", vals[2], 32'h41000000);
        check("rr data3", vals[3], 32'hbf800000);
        @(negedge clk);

        // Reset pulsed after beat 1: frame discarded, outputs cleared
        req0_valid = 1'b1;
        req0_data  = 32'h44000000;
        @(negedge clk);
        check("midrst granted", {31'd0, req0_ready}, 1);
        @(negedge clk);
        req0_data = 32'h45000000;
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("midrst o_valid", {31'd0, o_valid}, 0);
        check("midrst o_data", o_data, 0);
        check("midrst o_index", {30'd0, o_index}, 0);
        check("midrst o_id", {31'd0, o_id}, 0);
        check("midrst req0_ready", {31'd0, req0_ready}, 0);
        stray_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_valid || req0_ready) stray_valid = 1;
        end
        check("midrst quiet", {31'd0, stray_valid}, 0);
        send_frame(1'b0, 32'h3f800000, 32'h40a00000, 32'h40400000, -1, 0,
                   32'h40a00000, 2'd1, 4, "restart");

        // Equal values keep index 0, outputs hold afterwards
        send_frame(1'b1, 32'h42c80000, 32'h42c80000, 32'h42c80000, -1, 0,
                   32'h42c80000, 2'd0, 4, "equal");
        repeat (3) @(negedge clk);
        check("hold o_valid", {31'd0, o_valid}, 0);
        check("hold o_data", o_data, 32'h42c80000);
        check("hold o_index", {30'd0, o_index}, 0);
        check("hold o_id", {31'd0, o_id}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/target_max_arbiter.md
# target_max_arbiter

Shared max/argmax engine for Q-value frames, arbitrated between two requesters: requester 0 is the target-net output stream (max Q for the Bellman target) and requester 1 is the policy-net output stream (argmax for action selection). A grant locks one requester for a whole frame of NUMBER_OF_OUTPUT_NODE IEEE-754 single values. The engine compares the frame serially and returns the maximum value, its index and the requester ID. It sits between the two networks' output layers and the Q-target/action-select logic.

## Interface
- DATA_WIDTH, 32: float word width; only 32 (IEEE-754 single) is supported.
- NUMBER_OF_OUTPUT_NODE, 3: values per frame, ≥2.
- INDEX_WIDTH, 2: width of o_index, ≥ clog2(NUMBER_OF_OUTPUT_NODE).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset: synchronous and active-high (asserted = 1, sampled on clk).
- req0_valid  in  1  requester 0 beat valid.
- req0_data  in  DATA_WIDTH  requester 0 Q-value.
- req0_ready  out  1  requester 0 beat accepted when valid & ready.
- req1_valid / req1_data / req1_ready: same as above, for requester 1.
- o_valid  out  1  one-cycle result strobe.
- o_data  out  DATA_WIDTH  frame maximum.
- o_index  out  INDEX_WIDTH  position of the maximum (0 = first beat).
- o_id  out  1  requester that owned the frame.

## Operation
- States: IDLE, COLLECT.
- IDLE: both readies are 0. If any reqN_valid = 1, the requester is granted, the beat counter is cleared and the state goes to COLLECT. If both are valid, the requester with round-robin priority wins. After reset, priority goes to requester 0. After each completed frame, priority goes to the requester that was not served.
- COLLECT: ready = 1 for the granted requester only; the other requester's ready stays 0 (it stalls).
- Valid may drop mid-frame; this is a gap and the count is held. Data is not sampled without valid & ready.
- Beat 0 loads best_val and best_idx = 0.
- Beat k > 0 replaces the best only if it is strictly greater. Ties keep the earlier index.
- On the beat where count = NUMBER_OF_OUTPUT_NODE−1:
  - o_data, o_index and o_id are registered and o_valid = 1 on the next cycle.
  - The state returns to IDLE, the priority toggles and ready drops the same edge.
- Compare rule, on raw bits:
  - Both non-negative: unsigned compare.
  - Both negative: the smaller magnitude is greater.
  - Signs differ: the positive value is greater, except +0 and −0 are equal.
  - NaN and Inf get no special handling.
- o_data, o_index and o_id hold their values until the next result.

## Timing
- Reset values: state IDLE, req0_ready = req1_ready = 0, o_valid = 0, o_data = 0, o_index = 0, o_id = 0, priority = requester 0, counter 0.
- Grant latency: valid seen in IDLE at cycle t gives ready = 1 at t+1.
- Result latency: the last beat accepted at cycle c gives o_valid = 1 at c+1 for exactly one cycle.
- Back-to-back 3-beat frame: request at t, beats at t+1..t+3, o_valid at t+4. The next grant decision is made at t+4, so the next frame's beats start at t+5.
- Simultaneous requests are resolved by round-robin only; neither requester is starved beyond one frame.
- Reset mid-frame: the frame is discarded, no o_valid is produced and the requester must resend from beat 0.
- Reset while o_valid = 1: o_valid is 0 on the next cycle.

## Structure
- Shared package (dqn_pkg) holds:
  - FP32 field constants (sign bit 31, exponent 30:23, mantissa 22:0).
  - State encoding (IDLE, COLLECT).
  - Requester ID constants (REQ_TARGET = 0, REQ_POLICY = 1).
- Sub-module fp32_greater: combinational (a, b) → a_gt_b, implementing the compare rule above. It is reusable by the other max blocks.
- Top module holds the FSM, arbiter, beat counter, best registers and output registers.

## Test plan
- Req0 only, frame 42e26279, 42f3282c, 42c617e1 → o_valid once, o_data = 42f3282c, o_index = 1, o_id = 0, 4 cycles after the request.
- Req1 frame 42e26279, 42f3282c, 42f40000 with a 2-cycle valid gap after beat 1 → o_data = 42f40000, o_index = 2, o_id = 1; the gap is not counted.
- Negatives c0000000, bf800000, c0400000 → bf800000, index 1. Signed-zero tie 80000000, 00000000, 80000000 → o_data = 80000000, index 0.
- Both valid from reset, each holding 2 frames → grants alternate 0, 1, 0, 1; the losing ready stays 0 throughout the other's frame.
- rst_n pulsed after beat 1 of a frame → no o_valid; all outputs read 0; a restarted frame completes correctly.
- Equal values 42c80000 ×3 → index 0; o_data and o_index hold after o_valid falls.
